vram_rect_writer: RTL

- Write-side engine for the 1-bit-per-pixel 128x128 video frame BRAMs; the scanout path is the read side.
- Accepts drawing commands (plot pixel, fill rectangle, clear frame) over a valid/ready handshake.
- Walks the affected pixels in raster order and drives the BRAM write port at one pixel per granted cycle.
- An external arbiter gates each write with wr_grant.

---
 rtl/vram_rect_writer_if.sv | 43 ++++
 rtl/vram_rect_writer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/vram_rect_writer_if.sv
// Command handshake and BRAM write-port bundle for vram_rect_writer.
// cmd_pattern exists only when VRAM_WR_PATTERN_EN is defined.
interface vram_rect_writer_if #(
    parameter int unsigned X_W    = 7,
    parameter int unsigned Y_W    = 7,
    parameter int unsigned ADDR_W = 14
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [X_W-1:0]    cmd_x0;
    logic [Y_W-1:0]    cmd_y0;
    logic [X_W-1:0]    cmd_x1;
    logic [Y_W-1:0]    cmd_y1;
    logic              cmd_color;
`ifdef VRAM_WR_PATTERN_EN
    logic              cmd_pattern;
`endif
    logic              wr_grant;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_data;
    logic              busy;
    logic              done;

    modport master (
        output cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
`ifdef VRAM_WR_PATTERN_EN
        output cmd_pattern,
`endif
        output wr_grant,
        input  cmd_ready, wr_en, wr_addr, wr_data, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
`ifdef VRAM_WR_PATTERN_EN
        input  cmd_pattern,
`endif
        input  wr_grant,
        output cmd_ready, wr_en, wr_addr, wr_data, busy, done
    );
endinterface

// File: rtl/vram_rect_writer.sv
// Write-side engine for the 1bpp 128x128 frame BRAM: PLOT / FILL / CLEAR walked in raster order.
// Optional checkerboard pattern on wr_data enabled by defining VRAM_WR_PATTERN_EN.
module vram_rect_writer #(
    parameter int unsigned X_W    = 7,
    parameter int unsigned Y_W    = 7,
    parameter int unsigned ADDR_W = 14
) (
    input logic               clk,
    input logic               reset,
    vram_rect_writer_if.slave bus
);
    localparam logic [1:0] OP_PLOT  = 2'b00;
    localparam logic [1:0] OP_FILL  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FIN} state_t;

    state_t         state;
    logic [X_W-1:0] x, x0_q, x1_q;
    logic [Y_W-1:0] y, y1_q;
    logic           color_q;
    logic           ready_q, busy_q, done_q;
`ifdef VRAM_WR_PATTERN_EN
    logic           pattern_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            x       <= '0;
            y       <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            color_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef VRAM_WR_PATTERN_EN
            pattern_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.cmd_valid && ready_q) begin
                        ready_q <= 1'b0;
                        color_q <= bus.cmd_color;
`ifdef VRAM_WR_PATTERN_EN
                        pattern_q <= bus.cmd_pattern;
`endif
                        x0_q    <= bus.cmd_x0;
                        x       <= bus.cmd_x0;
                        y       <= bus.cmd_y0;
                        case (bus.cmd_op)
                            // PLOT reuses the rectangle walk as a 1x1 rectangle
                            OP_PLOT: begin
                                x1_q   <= bus.cmd_x0;
                                y1_q   <= bus.cmd_y0;
                                busy_q <= 1'b1;
                                state  <= S_WRITE;
                            end
                            OP_FILL: begin
                                x1_q <= bus.cmd_x1;
                                y1_q <= bus.cmd_y1;
                                if (bus.cmd_x1 < bus.cmd_x0 || bus.cmd_y1 < bus.cmd_y0) begin
                                    done_q <= 1'b1;
                                    state  <= S_FIN;
                                end else begin
                                    busy_q <= 1'b1;
                                    state  <= S_WRITE;
                                end
                            end
                            OP_CLEAR: begin
                                x      <= '0;
                                y      <= '0;
                                x0_q   <= '0;
                                x1_q   <= '1;
                                y1_q   <= '1;
                                busy_q <= 1'b1;
                                state  <= S_WRITE;
                            end
                            default: begin
                                done_q <= 1'b1;
                                state  <= S_FIN;
                            end
                        endcase
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (bus.wr_grant) begin
                        if (x == x1_q && y == y1_q) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= S_FIN;
                        end else if (x == x1_q) begin
                            x <= x0_q;
                            y <= y + Y_W'(1);
                        end else begin
                            x <= x + X_W'(1);
                        end
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The strobe follows the arbiter grant within the cycle; address and data come from the position registers.
    assign bus.wr_en     = busy_q & bus.wr_grant;
    assign bus.wr_addr   = {y, x};
`ifdef VRAM_WR_PATTERN_EN
    assign bus.wr_data   = color_q ^ (pattern_q & (x[0] ^ y[0]));
`else
    assign bus.wr_data   = color_q;
`endif
    assign bus.cmd_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule
